awgn_channel_sched: RTL

- Controller for the channel noise path. Sequences a two-state (good/bad) burst-error channel model, with programmable dwell lengths and transition probabilities.
- Selects which SNR noise LUT sample is applied, and adds it to the transmit sample stream over a valid/ready handshake.
- Sits between the modulator output and the demodulator input. Consumes the channel RNG integer and both noise LUT outputs.

---
 rtl/awgn_channel_sched.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/awgn_channel_sched.sv
// Two-state burst channel scheduler adding SNR-selected LUT noise to a sample stream.
// Define AWGN_SCHED_STATS_EN to build the transition / bad-sample counters.
module awgn_channel_sched #(
  parameter int          DATA_W   = 16,
  parameter int          DWELL_W  = 16,
  parameter logic [7:0]  GOOD_SNR = 8'd21,
  parameter logic [7:0]  BAD_SNR  = 8'd9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [DWELL_W-1:0] cfg_dwell_good,
  input  logic [DWELL_W-1:0] cfg_dwell_bad,
  input  logic [6:0]         cfg_p_gb,
  input  logic [6:0]         cfg_p_bg,
  input  logic [6:0]         rand_in,
  input  logic [DATA_W-1:0]  noise_good,
  input  logic [DATA_W-1:0]  noise_bad,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DATA_W-1:0]  s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [DATA_W-1:0]  m_data,
  output logic [7:0]         snr_state,
  output logic [15:0]        transitions,
  output logic [15:0]        bad_samples
);

  typedef enum logic [1:0] {
    IDLE,
    GOOD,
    BAD
  } state_e;

  state_e             state_q, state_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic               m_valid_q, m_valid_d;
  logic [DATA_W-1:0]  m_data_q, m_data_d;
  logic [7:0]         snr_q, snr_d;

  logic               accept;
  logic               eval;
  logic [DWELL_W-1:0] dwell_lim;
  logic [DATA_W-1:0]  noise;
  logic [DATA_W:0]    sum;
  logic [DATA_W-1:0]  sat;

  localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

  assign s_ready = !m_valid_q | m_ready;
  assign accept  = s_valid & s_ready;

  always_comb begin
    noise = '0;
    unique case (1'b1)
      (state_q == GOOD): noise = noise_good;
      (state_q == BAD):  noise = noise_bad;
      default:           noise = '0;
    endcase
  end

  always_comb begin
    sum = {s_data[DATA_W-1], s_data} + {noise[DATA_W-1], noise};
    sat = sum[DATA_W-1:0];
    if (sum[DATA_W] != sum[DATA_W-1]) begin
      sat = sum[DATA_W] ? MIN_V : MAX_V;
    end
  end

  // A shrunk dwell below the running count makes the next accept the evaluation.
  always_comb begin
    dwell_lim = (state_q == BAD) ? cfg_dwell_bad : cfg_dwell_good;
    if (dwell_lim == '0) begin
      dwell_lim = DWELL_W'(1);
    end
    eval = (dwell_cnt_q >= dwell_lim - DWELL_W'(1));
  end

  always_comb begin
    state_d     = state_q;
    dwell_cnt_d = dwell_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d     = GOOD;
          dwell_cnt_d = '0;
        end
      end
      GOOD, BAD: begin
        if (!enable) begin
          state_d     = IDLE;
          dwell_cnt_d = '0;
        end else if (accept) begin
          if (eval) begin
            dwell_cnt_d = '0;
            if (state_q == GOOD && rand_in < cfg_p_gb) begin
              state_d = BAD;
            end else if (state_q == BAD && rand_in < cfg_p_bg) begin
              state_d = GOOD;
            end
          end else begin
            dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
          end
        end
      end
      default: begin
        state_d     = IDLE;
        dwell_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    snr_d = 8'd0;
    unique case (1'b1)
      (state_d == GOOD): snr_d = GOOD_SNR;
      (state_d == BAD):  snr_d = BAD_SNR;
      default:           snr_d = 8'd0;
    endcase
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = sat;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      dwell_cnt_q <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      snr_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      dwell_cnt_q <= dwell_cnt_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      snr_q       <= snr_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign snr_state = snr_q;

`ifdef AWGN_SCHED_STATS_EN
  logic [15:0] trans_q, trans_d;
  logic [15:0] bad_q, bad_d;

  always_comb begin
    trans_d = trans_q;
    bad_d   = bad_q;
    if (state_q != IDLE && state_d != IDLE && state_q != state_d
        && trans_q != 16'hFFFF) begin
      trans_d = trans_q + 16'd1;
    end
    if (accept && state_q == BAD && bad_q != 16'hFFFF) begin
      bad_d = bad_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trans_q <= '0;
      bad_q   <= '0;
    end else begin
      trans_q <= trans_d;
      bad_q   <= bad_d;
    end
  end

  assign transitions = trans_q;
  assign bad_samples = bad_q;
`else
  assign transitions = 16'd0;
  assign bad_samples = 16'd0;
`endif

endmodule
